// File: rtl/spi_ram_sync.sv
// rtl/spi_ram_sync.sv - SPI/QSPI RAM peripheral oversampled in the system clock domain
// Optional debug read port (addr_in/byte_out) is built when DEBUG_PORT_EN is defined.
module spi_ram_sync #(
  parameter int RAM_ADDR_BITS = 6,
  parameter int ADDR_BYTES    = 3,
  parameter int DUMMY_CYCLES  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     spi_clk,
  input  logic                     spi_select,
  input  logic [3:0]               spi_d_in,
  output logic [3:0]               spi_d_out,
  output logic [3:0]               spi_d_oe
`ifdef DEBUG_PORT_EN
  ,
  input  logic [RAM_ADDR_BITS-1:0] addr_in,
  output logic [7:0]               byte_out
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_READ, S_WRITE, S_IGNORE
  } state_t;

  localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BYTES * 8 - 1);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

  logic [7:0] mem [2**RAM_ADDR_BITS];

  logic [2:0]               sclk_q, sclk_d;
  logic [1:0]               sel_q, sel_d;
  logic [3:0]               din1_q, din1_d, din2_q, din2_d;
  state_t                   state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [7:0]               sr_q, sr_d;
  logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic                     quad_q, quad_d, fast_q, fast_d, write_q, write_d;
  logic                     wr_en_q, wr_en_d;
  logic [7:0]               wr_data_q, wr_data_d;
  logic [3:0]               out_q, out_d, oe_q, oe_d;
  logic                     armed_q, armed_d;

  logic       sclk_rise, sclk_fall, cs_n, mosi;
  logic [7:0] rd_byte, rd_shift, cmd_byte;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_n      = sel_q[1];
  assign mosi      = din2_q[0];
  assign rd_byte   = mem[addr_q];
  assign rd_shift  = rd_byte << cnt_q[2:0];
  assign cmd_byte  = {sr_q[6:0], mosi};

  assign spi_d_out = out_q;
  assign spi_d_oe  = oe_q;

  // Next-state logic: synchronisers, command/address/data sequencing, deselect override
  always_comb begin
    sclk_d    = {sclk_q[1:0], spi_clk};
    sel_d     = {sel_q[0], spi_select};
    din1_d    = spi_d_in;
    din2_d    = din1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    addr_d    = addr_q;
    quad_d    = quad_q;
    fast_d    = fast_q;
    write_d   = write_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    out_d     = out_q;
    oe_d      = oe_q;
    // A transfer may only start after select has been seen high, so a reset
    // in the middle of a transfer does not resume on the remaining bits.
    armed_d   = armed_q | cs_n;
    if (wr_en_q) addr_d = addr_q + RAM_ADDR_BITS'(1);

    case (state_q)
      S_IDLE: begin
        if (!cs_n && armed_q) begin
          state_d = S_CMD;
          cnt_d   = 8'd0;
          oe_d    = 4'b0010;
          out_d   = 4'b0000;
        end
      end
      S_CMD: begin
        if (sclk_rise) begin
          sr_d  = cmd_byte;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            cnt_d   = 8'd0;
            quad_d  = (cmd_byte == 8'h6B) || (cmd_byte == 8'h32);
            fast_d  = (cmd_byte == 8'h0B) || (cmd_byte == 8'h6B);
            write_d = (cmd_byte == 8'h02) || (cmd_byte == 8'h32);
            case (cmd_byte)
              8'h03, 8'h0B, 8'h6B, 8'h02: state_d = S_ADDR;
              8'h32: begin
                state_d = S_ADDR;
                oe_d    = 4'b0000;
              end
              default: begin
                state_d = S_IGNORE;
                oe_d    = 4'b0000;
                out_d   = 4'b0000;
              end
            endcase
          end
        end
      end
      S_ADDR: begin
        if (sclk_rise) begin
          addr_d = {addr_q[RAM_ADDR_BITS-2:0], mosi};
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == ADDR_LAST) begin
            cnt_d = 8'd0;
            if (write_q)                             state_d = S_WRITE;
            else if (fast_q && (DUMMY_CYCLES > 0))   state_d = S_DUMMY;
            else                                     state_d = S_READ;
          end
        end
      end
      S_DUMMY: begin
        if (sclk_rise) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == DUMMY_LAST) begin
            cnt_d   = 8'd0;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (sclk_fall) begin
          cnt_d = cnt_q + 8'd1;
          if (quad_q) begin
            out_d = cnt_q[0] ? rd_byte[3:0] : rd_byte[7:4];
            oe_d  = 4'b1111;
            if (cnt_q[0]) begin
              cnt_d  = 8'd0;
              addr_d = addr_q + RAM_ADDR_BITS'(1);
            end
          end else begin
            out_d = {2'b00, rd_shift[7], 1'b0};
            if (cnt_q[2:0] == 3'd7) begin
              cnt_d  = 8'd0;
              addr_d = addr_q + RAM_ADDR_BITS'(1);
            end
          end
        end
      end
      S_WRITE: begin
        if (sclk_rise) begin
          if (quad_q) begin
            if (!cnt_q[0]) begin
              sr_d  = {din2_q, 4'b0000};
              cnt_d = 8'd1;
            end else begin
              wr_en_d   = 1'b1;
              wr_data_d = {sr_q[7:4], din2_q};
              cnt_d     = 8'd0;
            end
          end else begin
            sr_d  = {sr_q[6:0], mosi};
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'd7) begin
              wr_en_d   = 1'b1;
              wr_data_d = {sr_q[6:0], mosi};
              cnt_d     = 8'd0;
            end
          end
        end
      end
      S_IGNORE: begin
        oe_d  = 4'b0000;
        out_d = 4'b0000;
      end
      default: state_d = S_IDLE;
    endcase

    // Deselect wins over any edge seen in the same cycle; an incomplete byte is dropped.
    if (cs_n) begin
      state_d = S_IDLE;
      oe_d    = 4'b0000;
      out_d   = 4'b0000;
      wr_en_d = 1'b0;
    end
  end

  // State and output registers; the select synchroniser resets low so that
  // only a genuine select-high after reset arms the next transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q    <= 3'b000;
      sel_q     <= 2'b00;
      din1_q    <= 4'h0;
      din2_q    <= 4'h0;
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      sr_q      <= 8'h00;
      addr_q    <= '0;
      quad_q    <= 1'b0;
      fast_q    <= 1'b0;
      write_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 8'h00;
      out_q     <= 4'h0;
      oe_q      <= 4'h0;
      armed_q   <= 1'b0;
    end else begin
      sclk_q    <= sclk_d;
      sel_q     <= sel_d;
      din1_q    <= din1_d;
      din2_q    <= din2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      addr_q    <= addr_d;
      quad_q    <= quad_d;
      fast_q    <= fast_d;
      write_q   <= write_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
      armed_q   <= armed_d;
    end
  end

  // RAM write port: commits the byte assembled on the previous clk (contents not reset)
  always_ff @(posedge clk) begin
    if (wr_en_q) mem[addr_q] <= wr_data_q;
  end

`ifdef DEBUG_PORT_EN
  // Debug read port, independent of SPI activity, one clk of latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) byte_out <= 8'h00;
    else        byte_out <= mem[addr_in];
  end
`endif

endmodule
